// File: rtl/vga_fb_reader.sv
// vga_fb_reader: VGA timing generator that scans a synchronous-read
// framebuffer in raster order and drives registered colour and sync outputs.
// Counter state at cycle t appears as rd_addr at t+1, as rd_data at t+2 and
// as colour/sync/frame_start at t+3.
module vga_fb_reader #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic        clk,
  input  logic        rst,
  output logic [18:0] rd_addr,
  input  logic [11:0] rd_data,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  // Thresholds pre-sized to the counter widths so compares stay width-clean.
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_VIS_C  = HW'(H_VIS);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_VIS_C  = VW'(V_VIS);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_VIS + V_FP + V_SYNC);
  localparam logic [18:0]   H_VIS_19 = 19'(H_VIS);

  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;
  logic          w_h_wrap;
  logic          w_v_wrap;
  logic          w_de0;
  logic          w_hs0;
  logic          w_vs0;
  logic          w_first0;
  logic [18:0]   w_addr0;

  logic [18:0]   r_rd_addr;
  logic [2:0]    r_de;
  logic [2:0]    r_hs;
  logic [2:0]    r_vs;
  logic [2:0]    r_first;
  logic [11:0]   r_rgb;

  assign w_h_wrap = (r_hcnt == H_LAST);
  assign w_v_wrap = (r_vcnt == V_LAST);

  // Raster position: hcnt every clock, vcnt on each line wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_h_wrap) begin
      r_hcnt <= '0;
      r_vcnt <= w_v_wrap ? '0 : r_vcnt + 1'b1;
    end else begin
      r_hcnt <= r_hcnt + 1'b1;
    end
  end

  // Stage-0 decode of the current raster position (sync pulses active low).
  assign w_de0    = (r_hcnt < H_VIS_C) && (r_vcnt < V_VIS_C);
  assign w_hs0    = !((r_hcnt >= HS_BEG) && (r_hcnt < HS_END));
  assign w_vs0    = !((r_vcnt >= VS_BEG) && (r_vcnt < VS_END));
  assign w_first0 = (r_hcnt == '0) && (r_vcnt == '0);
  // Row-major address; the largest visible address fits comfortably in 19 bits.
  assign w_addr0  = 19'(r_vcnt) * H_VIS_19 + 19'(r_hcnt);

  // Read address plus three-stage alignment of de/sync/first-pixel flags.
  // Bit 0 lines up with rd_addr, bit 1 with rd_data, bit 2 with the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_addr <= '0;
      r_de      <= 3'b000;
      r_hs      <= 3'b111;
      r_vs      <= 3'b111;
      r_first   <= 3'b000;
    end else begin
      r_rd_addr <= w_de0 ? w_addr0 : 19'd0;
      r_de      <= {r_de[1:0], w_de0};
      r_hs      <= {r_hs[1:0], w_hs0};
      r_vs      <= {r_vs[1:0], w_vs0};
      r_first   <= {r_first[1:0], w_first0};
    end
  end

  // Colour capture: RAM data only while the aligned de is set, black otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rgb <= 12'h000;
    end else begin
      r_rgb <= r_de[1] ? rd_data : 12'h000;
    end
  end

  assign rd_addr     = r_rd_addr;
  assign red         = r_rgb[11:8];
  assign green       = r_rgb[7:4];
  assign blue        = r_rgb[3:0];
  assign hsync       = r_hs[2];
  assign vsync       = r_vs[2];
  assign frame_start = r_first[2];

endmodule

// File: tb/tb_vga_fb_reader.sv
// tb_vga_fb_reader: directed check of vga_fb_reader on a shrunken 16x8 raster
// (8x4 visible, hsync on h=10..12, vsync on lines 5..6), with a synchronous
// RAM model returning either addr[11:0] or a constant 12'hFFF.
module tb_vga_fb_reader;

  localparam int HV = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 3;
  localparam int VV = 4;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int HT = HV + HF + HS + HB;   // 16
  localparam int VT = VV + VF + VS + VB;   // 8
  localparam int FRAME = HT * VT;          // 128

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [18:0] rd_addr;
  logic [11:0] rd_data = 12'h000;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        hsync;
  logic        vsync;
  logic        frame_start;
  bit          ram_ff = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;
  int n        = 0;

  vga_fb_reader #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .hsync       (hsync),
    .vsync       (vsync),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Synchronous-read framebuffer model.
  always @(posedge clk) begin
    rd_data <= ram_ff ? 12'hFFF : rd_addr[11:0];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (n=%0d)", tag, obs, exp, n);
    end
  endtask

  // Expected outputs after counting edge k, derived from raster geometry.
  task automatic check_all(input int k, input bit ff);
    int q, h, v;
    bit de;
    logic [18:0] e_addr;
    logic [11:0] e_rgb;
    logic e_hs, e_vs, e_fs;
    q = k - 1;
    e_addr = 19'd0;
    if (q >= 0) begin
      h = q % HT;
      v = (q / HT) % VT;
      if (h < HV && v < VV) e_addr = 19'(v * HV + h);
    end
    q = k - 3;
    e_rgb = 12'h000; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0;
    if (q >= 0) begin
      h = q % HT;
      v = (q / HT) % VT;
      de = (h < HV) && (v < VV);
      if (de) e_rgb = ff ? 12'hFFF : 12'(v * HV + h);
      e_hs = !(h >= HV + HF && h < HV + HF + HS);
      e_vs = !(v >= VV + VF && v < VV + VF + VS);
      e_fs = (h == 0) && (v == 0);
    end
    chk("rd_addr", 32'(rd_addr), 32'(e_addr));
    chk("rgb", 32'({red, green, blue}), 32'(e_rgb));
    chk("hsync", 32'(hsync), 32'(e_hs));
    chk("vsync", 32'(vsync), 32'(e_vs));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    chk({tag, "_rgb"}, 32'({red, green, blue}), 32'd0);
    chk({tag, "_hsync"}, 32'(hsync), 32'd1);
    chk({tag, "_vsync"}, 32'(vsync), 32'd1);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
  endtask

  initial begin
    int fs_cnt, fs_first, fs_second, hs_low, vs_low, nz_cnt, last_addr, addr_order_err;
    fs_cnt = 0; fs_first = -1; fs_second = -1; hs_low = 0; vs_low = 0;
    nz_cnt = 0; last_addr = 0; addr_order_err = 0;

    // Reset held for several edges.
    rst = 1'b1;
    ram_ff = 1'b0;
    step(); step(); step();
    check_reset_vals("reset");

    // Release and run just over two frames with the addr-echo RAM.
    rst = 1'b0;
    n = 0;
    check_all(n, 1'b0);
    for (int i = 0; i < 2 * FRAME + 6; i++) begin
      step();
      n++;
      check_all(n, 1'b0);
      if (n == 3) begin
        chk("first_pixel_rgb", 32'({red, green, blue}), 32'h000);
        chk("first_frame_start", 32'(frame_start), 32'd1);
      end
      if (n == 4)  chk("pixel1_rgb", 32'({red, green, blue}), 32'h001);
      if (n == 10) chk("pixel7_rgb", 32'({red, green, blue}), 32'h007);
      if (n == 11) chk("hblank_black", 32'({red, green, blue}), 32'h000);
      if (n == 13) chk("hsync_first_low", 32'(hsync), 32'd0);
      if (n == 16) chk("hsync_back_high", 32'(hsync), 32'd1);
      if (n == 19) chk("line1_pixel0_rgb", 32'({red, green, blue}), 32'h008);
      if (frame_start) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = n;
        else if (fs_second < 0) fs_second = n;
      end
      if (n >= 3 && n < 3 + HT && !hsync) hs_low++;
      if (n >= 3 && n < 3 + FRAME && !vsync) vs_low++;
      if (n >= 1 && n <= FRAME && rd_addr != 19'd0) begin
        if (int'(rd_addr) != last_addr + 1) addr_order_err++;
        last_addr = int'(rd_addr);
        nz_cnt++;
      end
    end
    chk("frame_start_count", 32'(fs_cnt), 32'd3);
    chk("frame_start_first", 32'(fs_first), 32'd3);
    chk("frame_period", 32'(fs_second - fs_first), 32'd128);
    chk("hsync_low_clocks", 32'(hs_low), 32'd3);
    chk("vsync_low_clocks", 32'(vs_low), 32'd32);
    chk("nonzero_addr_count", 32'(nz_cnt), 32'd31);
    chk("last_addr", 32'(last_addr), 32'd31);
    chk("addr_ascending_errors", 32'(addr_order_err), 32'd0);

    // Advance to raster state (h=5, v=2), then pulse reset for one clock.
    while ((n % FRAME) != 2 * HT + 5) begin
      step();
      n++;
      check_all(n, 1'b0);
    end
    ram_ff = 1'b1;
    rst = 1'b1;
    step();
    check_reset_vals("midreset");
    rst = 1'b0;
    n = 0;

    // Constant-white RAM: only visible pixels may show 0xFFF.
    fs_cnt = 0;
    for (int i = 0; i < FRAME + 6; i++) begin
      step();
      n++;
      check_all(n, 1'b1);
      if (n == 1) chk("restart_addr0", 32'(rd_addr), 32'd0);
      if (n == 2) chk("restart_addr1", 32'(rd_addr), 32'd1);
      if (n == 3) begin
        chk("restart_frame_start", 32'(frame_start), 32'd1);
        chk("white_pixel0", 32'({red, green, blue}), 32'hFFF);
      end
      if (n == 11) chk("white_hblank_black", 32'({red, green, blue}), 32'h000);
      if (n == 3 + 4 * HT) chk("white_vblank_black", 32'({red, green, blue}), 32'h000);
      if (frame_start) fs_cnt++;
    end
    chk("restart_frame_start_count", 32'(fs_cnt), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
